// File: rtl/nvdla_cvsram_axi_slave.sv
// AXI4 responder modelling the NVDLA CVSRAM: independent single-burst write and
// read engines in front of a register-array memory of DEPTH 256-bit words.
module nvdla_cvsram_axi_slave #(
  parameter int          DEPTH     = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic         dla_core_clk,
  input  logic         dla_reset_rstn,
  input  logic [3:0]   nvdla_core2cvsram_aw_awid,
  input  logic [63:0]  nvdla_core2cvsram_aw_awaddr,
  input  logic [7:0]   nvdla_core2cvsram_aw_awlen,
  input  logic [2:0]   nvdla_core2cvsram_aw_awsize,
  input  logic [1:0]   nvdla_core2cvsram_aw_awburst,
  input  logic         nvdla_core2cvsram_aw_awlock,
  input  logic [3:0]   nvdla_core2cvsram_aw_awcache,
  input  logic [2:0]   nvdla_core2cvsram_aw_awprot,
  input  logic [3:0]   nvdla_core2cvsram_aw_awqos,
  input  logic [3:0]   nvdla_core2cvsram_aw_awregion,
  input  logic [31:0]  nvdla_core2cvsram_aw_awuser,
  input  logic         nvdla_core2cvsram_aw_awvalid,
  output logic         nvdla_core2cvsram_aw_awready,
  input  logic [7:0]   nvdla_core2cvsram_w_wid,
  input  logic [255:0] nvdla_core2cvsram_w_wdata,
  input  logic [31:0]  nvdla_core2cvsram_w_wstrb,
  input  logic         nvdla_core2cvsram_w_wlast,
  input  logic [31:0]  nvdla_core2cvsram_w_wuser,
  input  logic         nvdla_core2cvsram_w_wvalid,
  output logic         nvdla_core2cvsram_w_wready,
  output logic [5:0]   nvdla_core2cvsram_b_bid,
  output logic [1:0]   nvdla_core2cvsram_b_bresp,
  output logic [31:0]  nvdla_core2cvsram_b_buser,
  output logic         nvdla_core2cvsram_b_bvalid,
  input  logic         nvdla_core2cvsram_b_bready,
  input  logic [3:0]   nvdla_core2cvsram_ar_arid,
  input  logic [63:0]  nvdla_core2cvsram_ar_araddr,
  input  logic [7:0]   nvdla_core2cvsram_ar_arlen,
  input  logic [2:0]   nvdla_core2cvsram_ar_arsize,
  input  logic [1:0]   nvdla_core2cvsram_ar_arburst,
  input  logic         nvdla_core2cvsram_ar_arlock,
  input  logic [3:0]   nvdla_core2cvsram_ar_arcache,
  input  logic [2:0]   nvdla_core2cvsram_ar_arprot,
  input  logic [3:0]   nvdla_core2cvsram_ar_arqos,
  input  logic [3:0]   nvdla_core2cvsram_ar_arregion,
  input  logic [31:0]  nvdla_core2cvsram_ar_aruser,
  input  logic         nvdla_core2cvsram_ar_arvalid,
  output logic         nvdla_core2cvsram_ar_arready,
  output logic [5:0]   nvdla_core2cvsram_r_rid,
  output logic [255:0] nvdla_core2cvsram_r_rdata,
  output logic [1:0]   nvdla_core2cvsram_r_rresp,
  output logic [31:0]  nvdla_core2cvsram_r_ruser,
  output logic         nvdla_core2cvsram_r_rlast,
  output logic         nvdla_core2cvsram_r_rvalid,
  input  logic         nvdla_core2cvsram_r_rready
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [59:0] DEPTH_W = 60'(DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Bit 64 is the borrow, i.e. the address lies below BASE_ADDR.
  function automatic logic [64:0] addr_offset(input logic [63:0] addr);
    return {1'b0, addr} - {1'b0, BASE_ADDR};
  endfunction

  function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd5) || ((burst != 2'b00) && (burst != 2'b01));
  endfunction

  function automatic logic beat_hit(input logic low, input logic [59:0] word, input logic err);
    return !low && (word < DEPTH_W) && !err;
  endfunction

  function automatic logic [255:0] merge_bytes(input logic [255:0] old_d, input logic [255:0] new_d,
                                               input logic [31:0] strb);
    logic [255:0] res;
    res = old_d;
    for (int i = 0; i < 32; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return res;
  endfunction

  logic [255:0] mem_r [DEPTH];

  logic [64:0] aw_off_s, ar_off_s;
  assign aw_off_s = addr_offset(nvdla_core2cvsram_aw_awaddr);
  assign ar_off_s = addr_offset(nvdla_core2cvsram_ar_araddr);

  w_state_e    w_state_r, w_state_nxt_s;
  logic [59:0] w_word_r, w_word_nxt_s;
  logic        w_low_r, w_low_nxt_s, w_fixed_r, w_fixed_nxt_s, err_w_r, err_w_nxt_s;
  logic [7:0]  w_len_r, w_len_nxt_s, w_cnt_r, w_cnt_nxt_s;
  logic        awready_r, awready_nxt_s, wready_r, wready_nxt_s, bvalid_r, bvalid_nxt_s;
  logic [1:0]  bresp_r, bresp_nxt_s;
  logic [5:0]  bid_r, bid_nxt_s;
  logic        mem_we_s, w_last_s, w_hit_s;

  // Write engine next-state and registered-output values.
  always_comb begin
    w_state_nxt_s = w_state_r;
    w_word_nxt_s  = w_word_r;
    w_low_nxt_s   = w_low_r;
    w_fixed_nxt_s = w_fixed_r;
    err_w_nxt_s   = err_w_r;
    w_len_nxt_s   = w_len_r;
    w_cnt_nxt_s   = w_cnt_r;
    awready_nxt_s = awready_r;
    wready_nxt_s  = wready_r;
    bvalid_nxt_s  = bvalid_r;
    bresp_nxt_s   = bresp_r;
    bid_nxt_s     = bid_r;
    mem_we_s      = 1'b0;
    w_last_s      = (w_cnt_r == w_len_r);
    w_hit_s       = beat_hit(w_low_r, w_word_r, err_w_r);
    case (w_state_r)
      W_IDLE: begin
        if (nvdla_core2cvsram_aw_awvalid && awready_r) begin
          bid_nxt_s     = {2'b00, nvdla_core2cvsram_aw_awid};
          w_word_nxt_s  = {1'b0, aw_off_s[63:5]};
          w_low_nxt_s   = aw_off_s[64];
          w_len_nxt_s   = nvdla_core2cvsram_aw_awlen;
          w_fixed_nxt_s = (nvdla_core2cvsram_aw_awburst == 2'b00);
          err_w_nxt_s   = bad_cmd(nvdla_core2cvsram_aw_awsize, nvdla_core2cvsram_aw_awburst);
          w_cnt_nxt_s   = 8'd0;
          awready_nxt_s = 1'b0;
          wready_nxt_s  = 1'b1;
          w_state_nxt_s = W_DATA;
        end else begin
          w_state_nxt_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (nvdla_core2cvsram_w_wvalid && wready_r) begin
          mem_we_s    = w_hit_s;
          // A wlast in the wrong place flags the burst; len alone decides its length.
          err_w_nxt_s = err_w_r | !w_hit_s | (nvdla_core2cvsram_w_wlast != w_last_s);
          if (w_last_s) begin
            wready_nxt_s  = 1'b0;
            bvalid_nxt_s  = 1'b1;
            bresp_nxt_s   = err_w_nxt_s ? 2'b10 : 2'b00;
            w_state_nxt_s = W_RESP;
          end else begin
            w_cnt_nxt_s  = w_cnt_r + 8'd1;
            w_word_nxt_s = w_fixed_r ? w_word_r : (w_word_r + 60'd1);
          end
        end else begin
          w_state_nxt_s = W_DATA;
        end
      end
      W_RESP: begin
        if (nvdla_core2cvsram_b_bready) begin
          bvalid_nxt_s  = 1'b0;
          awready_nxt_s = 1'b1;
          w_state_nxt_s = W_IDLE;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: begin
        w_state_nxt_s = W_IDLE;
        awready_nxt_s = 1'b1;
        wready_nxt_s  = 1'b0;
        bvalid_nxt_s  = 1'b0;
      end
    endcase
  end

  // Write engine state and output registers.
  always_ff @(posedge dla_core_clk or negedge dla_reset_rstn) begin
    if (!dla_reset_rstn) begin
      w_state_r <= W_IDLE;
      w_word_r  <= 60'd0;
      w_low_r   <= 1'b0;
      w_fixed_r <= 1'b0;
      err_w_r   <= 1'b0;
      w_len_r   <= 8'd0;
      w_cnt_r   <= 8'd0;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      bid_r     <= 6'd0;
    end else begin
      w_state_r <= w_state_nxt_s;
      w_word_r  <= w_word_nxt_s;
      w_low_r   <= w_low_nxt_s;
      w_fixed_r <= w_fixed_nxt_s;
      err_w_r   <= err_w_nxt_s;
      w_len_r   <= w_len_nxt_s;
      w_cnt_r   <= w_cnt_nxt_s;
      awready_r <= awready_nxt_s;
      wready_r  <= wready_nxt_s;
      bvalid_r  <= bvalid_nxt_s;
      bresp_r   <= bresp_nxt_s;
      bid_r     <= bid_nxt_s;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge dla_core_clk) begin
    if (mem_we_s) begin
      mem_r[w_word_r[IDX_W-1:0]] <= merge_bytes(mem_r[w_word_r[IDX_W-1:0]],
                                                nvdla_core2cvsram_w_wdata, nvdla_core2cvsram_w_wstrb);
    end
  end

  r_state_e     r_state_r, r_state_nxt_s;
  logic [59:0]  r_word_r, r_word_nxt_s, rd_word_s;
  logic         r_low_r, r_low_nxt_s, r_fixed_r, r_fixed_nxt_s, err_r_r, err_r_nxt_s;
  logic [7:0]   r_len_r, r_len_nxt_s, r_cnt_r, r_cnt_nxt_s;
  logic         arready_r, arready_nxt_s, rvalid_r, rvalid_nxt_s, rlast_r, rlast_nxt_s;
  logic [1:0]   rresp_r, rresp_nxt_s;
  logic [5:0]   rid_r, rid_nxt_s;
  logic [255:0] rdata_r, rdata_nxt_s;
  logic         rd_load_s, rd_low_s, rd_err_s, rd_last_s, rd_hit_s;

  // Read engine: selects the beat to present next and loads its payload.
  always_comb begin
    r_state_nxt_s = r_state_r;
    r_len_nxt_s   = r_len_r;
    r_cnt_nxt_s   = r_cnt_r;
    r_fixed_nxt_s = r_fixed_r;
    arready_nxt_s = arready_r;
    rvalid_nxt_s  = rvalid_r;
    rlast_nxt_s   = rlast_r;
    rid_nxt_s     = rid_r;
    rd_load_s     = 1'b0;
    rd_word_s     = r_word_r;
    rd_low_s      = r_low_r;
    rd_err_s      = err_r_r;
    rd_last_s     = rlast_r;
    case (r_state_r)
      R_IDLE: begin
        if (nvdla_core2cvsram_ar_arvalid && arready_r) begin
          rid_nxt_s     = {2'b00, nvdla_core2cvsram_ar_arid};
          r_len_nxt_s   = nvdla_core2cvsram_ar_arlen;
          r_fixed_nxt_s = (nvdla_core2cvsram_ar_arburst == 2'b00);
          r_cnt_nxt_s   = 8'd0;
          rd_word_s     = {1'b0, ar_off_s[63:5]};
          rd_low_s      = ar_off_s[64];
          rd_err_s      = bad_cmd(nvdla_core2cvsram_ar_arsize, nvdla_core2cvsram_ar_arburst);
          rd_last_s     = (nvdla_core2cvsram_ar_arlen == 8'd0);
          rd_load_s     = 1'b1;
          arready_nxt_s = 1'b0;
          r_state_nxt_s = R_DATA;
        end else begin
          r_state_nxt_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_r && nvdla_core2cvsram_r_rready) begin
          if (rlast_r) begin
            rvalid_nxt_s  = 1'b0;
            rlast_nxt_s   = 1'b0;
            arready_nxt_s = 1'b1;
            r_state_nxt_s = R_IDLE;
          end else begin
            rd_word_s   = r_fixed_r ? r_word_r : (r_word_r + 60'd1);
            r_cnt_nxt_s = r_cnt_r + 8'd1;
            rd_last_s   = ((r_cnt_r + 8'd1) == r_len_r);
            rd_load_s   = 1'b1;
          end
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: begin
        r_state_nxt_s = R_IDLE;
        arready_nxt_s = 1'b1;
        rvalid_nxt_s  = 1'b0;
        rlast_nxt_s   = 1'b0;
      end
    endcase
    rd_hit_s = beat_hit(rd_low_s, rd_word_s, rd_err_s);
    if (rd_load_s) begin
      rvalid_nxt_s = 1'b1;
      rlast_nxt_s  = rd_last_s;
      rresp_nxt_s  = rd_hit_s ? 2'b00 : 2'b10;
      rdata_nxt_s  = rd_hit_s ? mem_r[rd_word_s[IDX_W-1:0]] : 256'd0;
      r_word_nxt_s = rd_word_s;
      r_low_nxt_s  = rd_low_s;
      err_r_nxt_s  = rd_err_s;
    end else begin
      rresp_nxt_s  = rresp_r;
      rdata_nxt_s  = rdata_r;
      r_word_nxt_s = r_word_r;
      r_low_nxt_s  = r_low_r;
      err_r_nxt_s  = err_r_r;
    end
  end

  // Read engine state and output registers.
  always_ff @(posedge dla_core_clk or negedge dla_reset_rstn) begin
    if (!dla_reset_rstn) begin
      r_state_r <= R_IDLE;
      r_word_r  <= 60'd0;
      r_low_r   <= 1'b0;
      r_fixed_r <= 1'b0;
      err_r_r   <= 1'b0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rresp_r   <= 2'b00;
      rid_r     <= 6'd0;
      rdata_r   <= 256'd0;
    end else begin
      r_state_r <= r_state_nxt_s;
      r_word_r  <= r_word_nxt_s;
      r_low_r   <= r_low_nxt_s;
      r_fixed_r <= r_fixed_nxt_s;
      err_r_r   <= err_r_nxt_s;
      r_len_r   <= r_len_nxt_s;
      r_cnt_r   <= r_cnt_nxt_s;
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rlast_r   <= rlast_nxt_s;
      rresp_r   <= rresp_nxt_s;
      rid_r     <= rid_nxt_s;
      rdata_r   <= rdata_nxt_s;
    end
  end

  assign nvdla_core2cvsram_aw_awready = awready_r;
  assign nvdla_core2cvsram_w_wready   = wready_r;
  assign nvdla_core2cvsram_b_bvalid   = bvalid_r;
  assign nvdla_core2cvsram_b_bresp    = bresp_r;
  assign nvdla_core2cvsram_b_bid      = bid_r;
  assign nvdla_core2cvsram_b_buser    = 32'd0;
  assign nvdla_core2cvsram_ar_arready = arready_r;
  assign nvdla_core2cvsram_r_rvalid   = rvalid_r;
  assign nvdla_core2cvsram_r_rlast    = rlast_r;
  assign nvdla_core2cvsram_r_rresp    = rresp_r;
  assign nvdla_core2cvsram_r_rid      = rid_r;
  assign nvdla_core2cvsram_r_rdata    = rdata_r;
  assign nvdla_core2cvsram_r_ruser    = 32'd0;

  logic unused_s;
  assign unused_s = ^{nvdla_core2cvsram_aw_awlock, nvdla_core2cvsram_aw_awcache, nvdla_core2cvsram_aw_awprot,
                      nvdla_core2cvsram_aw_awqos, nvdla_core2cvsram_aw_awregion, nvdla_core2cvsram_aw_awuser,
                      nvdla_core2cvsram_w_wid, nvdla_core2cvsram_w_wuser,
                      nvdla_core2cvsram_ar_arlock, nvdla_core2cvsram_ar_arcache, nvdla_core2cvsram_ar_arprot,
                      nvdla_core2cvsram_ar_arqos, nvdla_core2cvsram_ar_arregion, nvdla_core2cvsram_ar_aruser,
                      aw_off_s[4:0], ar_off_s[4:0]};

endmodule

// File: tb/tb_nvdla_cvsram_axi_slave.sv
// Directed bench for nvdla_cvsram_axi_slave: hand-computed expectations checked
// with immediate assertions at each observation point.
module tb_nvdla_cvsram_axi_slave;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   awid, arid;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst;
  logic         awvalid, awready, arvalid, arready;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb, buser, ruser;
  logic         wlast, wvalid, wready;
  logic [5:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;
  int beat;
  logic tog;

  always #5 clk = ~clk;

  nvdla_cvsram_axi_slave dut (
    .dla_core_clk(clk), .dla_reset_rstn(rstn),
    .nvdla_core2cvsram_aw_awid(awid), .nvdla_core2cvsram_aw_awaddr(awaddr),
    .nvdla_core2cvsram_aw_awlen(awlen), .nvdla_core2cvsram_aw_awsize(awsize),
    .nvdla_core2cvsram_aw_awburst(awburst), .nvdla_core2cvsram_aw_awlock(1'b0),
    .nvdla_core2cvsram_aw_awcache(4'd0), .nvdla_core2cvsram_aw_awprot(3'd0),
    .nvdla_core2cvsram_aw_awqos(4'd0), .nvdla_core2cvsram_aw_awregion(4'd0),
    .nvdla_core2cvsram_aw_awuser(32'd0), .nvdla_core2cvsram_aw_awvalid(awvalid),
    .nvdla_core2cvsram_aw_awready(awready),
    .nvdla_core2cvsram_w_wid(8'd0), .nvdla_core2cvsram_w_wdata(wdata),
    .nvdla_core2cvsram_w_wstrb(wstrb), .nvdla_core2cvsram_w_wlast(wlast),
    .nvdla_core2cvsram_w_wuser(32'd0), .nvdla_core2cvsram_w_wvalid(wvalid),
    .nvdla_core2cvsram_w_wready(wready),
    .nvdla_core2cvsram_b_bid(bid), .nvdla_core2cvsram_b_bresp(bresp),
    .nvdla_core2cvsram_b_buser(buser), .nvdla_core2cvsram_b_bvalid(bvalid),
    .nvdla_core2cvsram_b_bready(bready),
    .nvdla_core2cvsram_ar_arid(arid), .nvdla_core2cvsram_ar_araddr(araddr),
    .nvdla_core2cvsram_ar_arlen(arlen), .nvdla_core2cvsram_ar_arsize(arsize),
    .nvdla_core2cvsram_ar_arburst(arburst), .nvdla_core2cvsram_ar_arlock(1'b0),
    .nvdla_core2cvsram_ar_arcache(4'd0), .nvdla_core2cvsram_ar_arprot(3'd0),
    .nvdla_core2cvsram_ar_arqos(4'd0), .nvdla_core2cvsram_ar_arregion(4'd0),
    .nvdla_core2cvsram_ar_aruser(32'd0), .nvdla_core2cvsram_ar_arvalid(arvalid),
    .nvdla_core2cvsram_ar_arready(arready),
    .nvdla_core2cvsram_r_rid(rid), .nvdla_core2cvsram_r_rdata(rdata),
    .nvdla_core2cvsram_r_rresp(rresp), .nvdla_core2cvsram_r_ruser(ruser),
    .nvdla_core2cvsram_r_rlast(rlast), .nvdla_core2cvsram_r_rvalid(rvalid),
    .nvdla_core2cvsram_r_rready(rready)
  );

  function automatic logic [255:0] pat(input logic [31:0] seed, input int i);
    logic [31:0] w;
    w = seed + 32'(i);
    return {8{w}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int n = 0; n < 50 && awready !== 1'b1; n++) @(negedge clk);
    chk("aw_ready", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [255:0] d, input logic [31:0] s, input logic last);
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    for (int n = 0; n < 50 && wready !== 1'b1; n++) @(negedge clk);
    chk("w_ready", wready, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic do_b(input string tag, input logic [1:0] resp, input logic [3:0] id);
    bready = 1'b1;
    for (int n = 0; n < 50 && bvalid !== 1'b1; n++) @(negedge clk);
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, resp);
    chk({tag, "_bid"}, bid, {2'b00, id});
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int n = 0; n < 50 && arready !== 1'b1; n++) @(negedge clk);
    chk("ar_ready", arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_r(input string tag, input logic [3:0] id, input logic [255:0] d,
                      input logic [1:0] resp, input logic last);
    rready = 1'b1;
    for (int n = 0; n < 50 && rvalid !== 1'b1; n++) @(negedge clk);
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rid"}, rid, {2'b00, id});
    chk({tag, "_rdata"}, rdata, d);
    chk({tag, "_rresp"}, rresp, resp);
    chk({tag, "_rlast"}, rlast, last);
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [31:0] seed,
                    input logic [1:0] resp);
    do_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) do_w(pat(seed, i), 32'hFFFF_FFFF, i == int'(len));
    do_b(tag, resp, id);
  endtask

  // Beats below n_ok return pat(seed, step ? i : 0) with OKAY, the rest zero with SLVERR.
  task automatic rd(input string tag, input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [31:0] seed, input int n_ok, input logic step);
    do_ar(id, addr, len, 3'd5, burst);
    for (int i = 0; i <= int'(len); i++) begin
      if (i < n_ok) do_r(tag, id, pat(seed, step ? i : 0), 2'b00, i == int'(len));
      else          do_r(tag, id, 256'd0, 2'b10, i == int'(len));
    end
  endtask

  initial begin
    rstn = 1'b0;
    awid = 4'd0; awaddr = 64'd0; awlen = 8'd0; awsize = 3'd5; awburst = 2'b01; awvalid = 1'b0;
    arid = 4'd0; araddr = 64'd0; arlen = 8'd0; arsize = 3'd5; arburst = 2'b01; arvalid = 1'b0;
    wdata = 256'd0; wstrb = 32'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 256'd0);
    rstn = 1'b1;
    @(negedge clk);

    wr("incr_wr", 4'h5, 64'h40, 8'd3, 3'd5, 2'b01, 32'hD000_0000, 2'b00);
    rd("incr_rd", 4'h9, 64'h40, 8'd3, 2'b01, 32'hD000_0000, 4, 1'b1);

    do_aw(4'h1, 64'h400, 8'd0, 3'd5, 2'b01);
    do_w({256{1'b1}}, 32'hFFFF_FFFF, 1'b1);
    do_b("ones_wr", 2'b00, 4'h1);
    do_aw(4'h1, 64'h400, 8'd0, 3'd5, 2'b01);
    do_w({32{8'hAA}}, 32'h0000_000F, 1'b1);
    do_b("strb_wr", 2'b00, 4'h1);
    do_ar(4'h2, 64'h400, 8'd0, 3'd5, 2'b01);
    do_r("strb_rd", 4'h2, {{224{1'b1}}, 32'hAAAA_AAAA}, 2'b00, 1'b1);

    wr("size_wr", 4'h3, 64'h40, 8'd1, 3'd4, 2'b01, 32'h1111_0000, 2'b10);
    wr("burst_wr", 4'h3, 64'h40, 8'd0, 3'd5, 2'b10, 32'h2222_0000, 2'b10);
    rd("unch_rd", 4'h4, 64'h40, 8'd1, 2'b01, 32'hD000_0000, 2, 1'b1);
    rd("burst_rd", 4'h4, 64'h40, 8'd1, 2'b10, 32'hD000_0000, 0, 1'b1);

    wr("top_wr", 4'h6, 64'h1FC0, 8'd1, 3'd5, 2'b01, 32'hE000_0000, 2'b00);
    rd("edge_rd", 4'h7, 64'h1FC0, 8'd3, 2'b01, 32'hE000_0000, 2, 1'b1);
    wr("edge_wr", 4'h6, 64'h1FE0, 8'd3, 3'd5, 2'b01, 32'hF000_0000, 2'b10);
    rd("edge_wr_rd", 4'h7, 64'h1FE0, 8'd0, 2'b01, 32'hF000_0000, 1, 1'b1);

    wr("fixed_wr", 4'h8, 64'h500, 8'd1, 3'd5, 2'b00, 32'hB000_0000, 2'b00);
    rd("fixed_rd", 4'h8, 64'h500, 8'd1, 2'b00, 32'hB000_0001, 2, 1'b0);

    do_aw(4'hA, 64'h520, 8'd1, 3'd5, 2'b01);
    do_w(pat(32'h3300_0000, 0), 32'hFFFF_FFFF, 1'b1);
    do_w(pat(32'h3300_0000, 1), 32'hFFFF_FFFF, 1'b0);
    do_b("wlast_wr", 2'b10, 4'hA);

    wr("stall_wr", 4'h2, 64'h800, 8'd7, 3'd5, 2'b01, 32'hC000_0000, 2'b00);
    do_ar(4'h2, 64'h800, 8'd7, 3'd5, 2'b01);
    beat = 0;
    tog = 1'b0;
    for (int n = 0; n < 40 && beat < 8; n++) begin
      tog = ~tog;
      rready = tog;
      if (rvalid === 1'b1) begin
        chk("stall_rdata", rdata, pat(32'hC000_0000, beat));
        chk("stall_rlast", rlast, beat == 7);
        if (rready) beat++;
      end
      @(negedge clk);
    end
    rready = 1'b0;
    chk("stall_beats", 256'(beat), 256'd8);
    chk("stall_end_rvalid", rvalid, 1'b0);
    chk("stall_end_arready", arready, 1'b1);

    do_aw(4'hB, 64'h840, 8'd0, 3'd5, 2'b01);
    do_w(pat(32'h4400_0000, 0), 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("bhold_bvalid", bvalid, 1'b1);
      chk("bhold_awready", awready, 1'b0);
      chk("bhold_bresp", bresp, 2'b00);
      @(negedge clk);
    end
    do_b("bhold", 2'b00, 4'hB);
    chk("bdone_awready", awready, 1'b1);
    chk("bdone_bvalid", bvalid, 1'b0);

    do_aw(4'hC, 64'h600, 8'd3, 3'd5, 2'b01);
    do_w(pat(32'h6600_0000, 0), 32'hFFFF_FFFF, 1'b0);
    wdata = pat(32'h6600_0000, 1); wvalid = 1'b1; wlast = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_wready", wready, 1'b0);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_arready", arready, 1'b1);
    wvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_bvalid", bvalid, 1'b0);
    end
    wr("after_rst_wr", 4'hD, 64'h600, 8'd0, 3'd5, 2'b01, 32'h5555_0000, 2'b00);
    rd("after_rst_rd", 4'hD, 64'h600, 8'd0, 2'b01, 32'h5555_0000, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvdla_cvsram_axi_slave.md
Name: nvdla_cvsram_axi_slave

Overview:
- AXI4 responder: the memory-side end of the NVDLA core2cvsram port.
- Accepts the core's AW/W/AR traffic and returns B/R responses from an internal register-array SRAM of DEPTH 256-bit words.
- Used as the on-chip CVSRAM model and as the bench target for the NVDLA top.
- One write burst and one read burst are in flight at a time; the two channels run independently.

Parameters:
- DEPTH, 256, number of 256-bit words; power of two, at least 2.
- BASE_ADDR, 64'h0, byte address of word 0.

Ports:
- dla_core_clk  input  1  clock
- dla_reset_rstn  input  1  asynchronous active-low reset
- nvdla_core2cvsram_aw_awid  input  4  write ID
- nvdla_core2cvsram_aw_awaddr  input  64  write byte address
- nvdla_core2cvsram_aw_awlen  input  8  beats minus 1
- nvdla_core2cvsram_aw_awsize  input  3  beat size; only 3'd5 (32 B) supported
- nvdla_core2cvsram_aw_awburst  input  2  2'b00 FIXED, 2'b01 INCR; others are errors
- aw_awlock/awcache/awprot/awqos/awregion/awuser  input  1/4/3/4/4/32  accepted and ignored
- nvdla_core2cvsram_aw_awvalid / _aw_awready  input / output  1  AW handshake
- nvdla_core2cvsram_w_wid  input  8  ignored
- nvdla_core2cvsram_w_wdata  input  256  write data
- nvdla_core2cvsram_w_wstrb  input  32  byte enables
- nvdla_core2cvsram_w_wlast / _w_wuser  input  1/32  last beat flag / ignored
- nvdla_core2cvsram_w_wvalid / _w_wready  input / output  1  W handshake
- nvdla_core2cvsram_b_bid  output  6  {2'b00, captured awid}
- nvdla_core2cvsram_b_bresp / _b_buser  output  2/32  response / always 0
- nvdla_core2cvsram_b_bvalid / _b_bready  output / input  1  B handshake
- nvdla_core2cvsram_ar_ar{id,addr,len,size,burst}  input  4/64/8/3/2  same rules as AW
- ar_arlock/arcache/arprot/arqos/arregion/aruser  input  1/4/3/4/4/32  accepted and ignored
- nvdla_core2cvsram_ar_arvalid / _ar_arready  input / output  1  AR handshake
- nvdla_core2cvsram_r_rid  output  6  {2'b00, captured arid}
- nvdla_core2cvsram_r_rdata / _r_rresp / _r_ruser  output  256/2/32  read data / response / always 0
- nvdla_core2cvsram_r_rlast / _r_rvalid / _r_rready  output / output / input  1  R channel

Behaviour:
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0, and both FSMs in IDLE.
- Reset is asynchronous; asserting it mid-burst aborts the burst with no response. Memory contents are not reset.
- Word index = (addr - BASE_ADDR) >> 5; addr[4:0] is ignored. A beat is in range iff addr >= BASE_ADDR and index < DEPTH.
- Beat address: INCR adds 1 word per beat; FIXED repeats the start index.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, capture id, index, len and burst; set err_w if awsize!=5 or awburst is not FIXED/INCR. Go to W_DATA, awready=0, wready=1.
  - W_DATA: on each wvalid&wready, write the bytes enabled by wstrb to mem[idx], but only if the beat is in range and err_w=0. Otherwise discard the beat and set err_w.
  - W_DATA, last beat: the beat count equals len. If wlast disagrees with that beat position (early or missing), set err_w. Burst length is governed only by len.
  - After the last beat: wready=0, bvalid=1, bresp = err_w ? 2'b10 (SLVERR) : 2'b00; enter W_RESP.
  - W_RESP: hold bvalid/bresp/bid stable until bready. Then bvalid=0, awready=1, return to W_IDLE. The next AW is accepted no earlier than the cycle after the B handshake.
- Read FSM, states R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On handshake, capture id/len/burst and set err_r using the AW rules.
  - Registered read, one cycle after the AR handshake: rvalid=1, rdata=mem[idx], or 0 if the beat is out of range or err_r=1. rresp is per beat: SLVERR if err_r or out of range, else OKAY. rlast = (len==0). arready=0.
  - R_DATA: rid/rdata/rresp/rlast are held stable while rvalid&!rready.
  - On rvalid&rready with a non-last beat: load the next beat in the same edge, so back-to-back beats have no bubble.
  - On the last beat: rvalid=0, rlast=0, arready=1, return to R_IDLE.
- Read and write to the same word in the same cycle: the read returns the old data.
- len=255 INCR crossing the DEPTH boundary: in-range beats complete normally; the remaining beats take the error path above. There is no wrap-around.

Test Plan:
- Reset -> awready=1, arready=1, bvalid=0, rvalid=0. Then INCR write at addr 0x40, len=3, wstrb all ones, data D0..D3 -> bresp=00, bid={2'b00, awid}; read of the same burst returns D0..D3 with rlast only on beat 3, rresp=00.
- Write with wstrb=32'h0000_000F of 0xAA.. over an all-ones word -> readback 0xFF..FF_AAAAAAAA, i.e. only the low 4 bytes change.
- awsize=3'd4 or awburst=2'b10 -> all beats consumed, memory unchanged, bresp=10. A read with arburst=2'b10 returns rresp=10, rdata=0 on every beat.
- INCR read len=3 starting at word DEPTH-2 -> beats 0-1 return OKAY with stored data; beats 2-3 return SLVERR with rdata=0.
- rready toggled 1/0 per cycle during a len=7 read -> 8 beats delivered with payload held across stalls. bready held low for 5 cycles -> bvalid stays high and awready stays 0 until the B handshake.
- dla_reset_rstn pulsed low in the middle of a write burst -> all outputs return to reset values immediately; no B is issued; the next write completes normally.
